// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/port encodings and memory geometry for the memory arbiter
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    localparam int MEM_ADDR_BITS = 10;

endpackage

// File: rtl/mem_arb_rr.sv
// mem_arb_rr: combinational 2-way round-robin pick; a tie goes to the port not served last
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] elig,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = elig[0] & (~elig[1] | (last == PORT_D));
    assign gnt[1] = elig[1] & (~elig[0] | (last == PORT_I));

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a single-port 1024-word memory between an instruction-read port
// and a data read/write port, one registered access per grant with a registered response
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_valid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          mem_ren,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          addr_err
);

    state_t        state, state_nx;
    port_t         last;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] win_addr;
    logic [1:0]    elig, pick;
    logic          access, serve_i, serve_d;

    assign access  = state == ACCESS;
    assign serve_i = access && last == PORT_I;
    assign serve_d = access && last == PORT_D;
    // the port being served still shows its stale req at the edge ending its access
    assign elig     = {d_req & ~serve_d, i_req & ~serve_i};
    assign win_addr = pick[1] ? d_addr : i_addr;

    mem_arb_rr u_rr (
        .elig (elig),
        .last (last),
        .gnt  (pick)
    );

    always_comb begin
        state_nx = |pick ? ACCESS : IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last     <= PORT_D;
            we       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            addr_err <= 1'b0;
        end else if (|pick) begin
            last     <= pick[1] ? PORT_D : PORT_I;
            we       <= pick[1] & d_we;
            addr     <= win_addr;
            wdata    <= pick[1] ? d_wdata : '0;
            addr_err <= addr_err | (|win_addr[AW-1:MEM_ADDR_BITS]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            i_valid <= serve_i;
            d_valid <= serve_d;
            if (serve_i)
                i_rdata <= mem_dout;
            if (serve_d && !we)
                d_rdata <= mem_dout;
        end
    end

    assign i_gnt    = serve_i;
    assign d_gnt    = serve_d;
    assign mem_ren  = access & ~we;
    assign mem_wen  = access & we;
    assign mem_addr = access ? addr : '0;
    assign mem_din  = access ? wdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level
// reference (grant rules, reference memory image, sticky address error)
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_valid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_valid;
    logic [31:0] d_rdata;
    logic        mem_ren, mem_wen;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        addr_err;

    mem_arbiter #(.AW(32), .DW(32)) dut (
        .clock    (clock),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_gnt    (i_gnt),
        .i_valid  (i_valid),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_valid  (d_valid),
        .d_rdata  (d_rdata),
        .mem_ren  (mem_ren),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .addr_err (addr_err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(int i);
        return (i == 32) ? 32'h11111111 : 32'h5A000000 + 32'(i) * 32'h00010007;
    endfunction

    // Memory: combinational read, write committed on the falling edge
    logic [31:0] mem [1024];
    bit          load = 1'b1;
    always @(negedge clock) begin
        if (load) begin
            for (int i = 0; i < 1024; i++)
                mem[i] <= init_word(i);
            load <= 1'b0;
        end else if (mem_wen)
            mem[mem_addr[9:0]] <= mem_din;
    end
    assign mem_dout = mem[mem_addr[9:0]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // reference: port in access (0 none, 1 I, 2 D), last served, memory image
    logic [31:0] ref_mem [1024];
    int          cur = 0;
    int          last_m = 2;
    bit          cur_we = 1'b0;
    bit          err_m = 1'b0;
    logic [31:0] exp_rd = '0;
    logic [31:0] pend_a = '0;
    logic [31:0] pend_d = '0;
    bit          gi = 1'b0, gd = 1'b0;
    bit          ic = 1'b0, dc = 1'b0;
    int          cyc = 0;

    task automatic cycle();
        bit          ri, rd, w;
        logic [31:0] ai, ad, wd, a;
        int          win;
        ri = i_req; rd = d_req; w = d_we; ai = i_addr; ad = d_addr; wd = d_wdata;
        @(posedge clock);
        #1;
        cyc++;
        chk("i_valid", i_valid, cur == 1);
        chk("d_valid", d_valid, cur == 2);
        if (cur == 1)
            chk("i_rdata", i_rdata, exp_rd);
        if (cur == 2 && !cur_we)
            chk("d_rdata", d_rdata, exp_rd);
        if (cur == 2 && cur_we)
            ref_mem[pend_a[9:0]] = pend_d;
        win = 0;
        if (ri && cur != 1 && rd && cur != 2)
            win = (last_m == 2) ? 1 : 2;
        else if (ri && cur != 1)
            win = 1;
        else if (rd && cur != 2)
            win = 2;
        chk("i_gnt", i_gnt, win == 1);
        chk("d_gnt", d_gnt, win == 2);
        if (win != 0) begin
            last_m = win;
            a = (win == 1) ? ai : ad;
            cur_we = (win == 2) && w;
            if (a[31:10] != 0)
                err_m = 1'b1;
            if (!cur_we)
                exp_rd = ref_mem[a[9:0]];
            pend_a = a;
            pend_d = wd;
            chk("mem_ren", mem_ren, !cur_we);
            chk("mem_wen", mem_wen, cur_we);
            chk("mem_addr", mem_addr, a);
            if (cur_we)
                chk("mem_din", mem_din, wd);
        end else begin
            chk("idle_ren", mem_ren, 0);
            chk("idle_wen", mem_wen, 0);
            chk("idle_addr", mem_addr, 0);
            chk("idle_din", mem_din, 0);
        end
        chk("addr_err", addr_err, err_m);
        cur = win;
        gi = (win == 1);
        gd = (win == 2);
    endtask

    task automatic apply_reset(int n);
        reset = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (n) @(posedge clock);
        #1 reset = 1'b0;
        cur = 0; last_m = 2; err_m = 1'b0; cur_we = 1'b0;
        gi = 1'b0; gd = 1'b0; ic = 1'b0; dc = 1'b0;
        chk("rst_i_gnt", i_gnt, 0);
        chk("rst_d_gnt", d_gnt, 0);
        chk("rst_i_valid", i_valid, 0);
        chk("rst_d_valid", d_valid, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        chk("rst_mem", {mem_ren, mem_wen, mem_addr, mem_din}, 0);
        chk("rst_addr_err", addr_err, 0);
    endtask

    task automatic d_op(input bit we, input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
        do begin
            cycle();
            n++;
        end while (!gd && n < 10);
        chk("d_op_grant", gd, 1);
        cycle();
        d_req = 1'b0;
    endtask

    task automatic run(int n, int mode);
        for (int k = 0; k < n; k++) begin
            cycle();
            if (ic) begin
                i_req = (mode == 1) || ($urandom_range(0, 3) != 0);
                i_addr = 32'($urandom_range(0, 1023));
                ic = 1'b0;
            end else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1'b1;
                i_addr = 32'($urandom_range(0, 1023));
            end
            if (gi)
                ic = 1'b1;
            if (dc) begin
                d_req = (mode == 1) || ($urandom_range(0, 3) != 0);
                d_we = $urandom_range(0, 1) == 1;
                d_addr = 32'($urandom_range(0, 63));
                d_wdata = $urandom;
                dc = 1'b0;
            end else if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1'b1;
                d_we = $urandom_range(0, 1) == 1;
                d_addr = 32'($urandom_range(0, 63));
                d_wdata = $urandom;
            end
            if (gd)
                dc = 1'b1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, prev;
        logic [31:0] seq [3];
        seq[0] = 32'h4; seq[1] = 32'h8; seq[2] = 32'hC;
        for (int i = 0; i < 1024; i++)
            ref_mem[i] = init_word(i);

        apply_reset(2);
        repeat (5) cycle();

        d_op(1'b1, 32'h10, 32'hCAFEF00D);
        d_op(1'b0, 32'h10, 32'h0);
        chk("wr_rd_data", d_rdata, 32'hCAFEF00D);

        // single port holding req: grants every 2nd cycle
        i_req = 1'b1;
        prev = 0;
        for (int s = 0; s < 3; s++) begin
            i_addr = seq[s];
            n = 0;
            do begin
                cycle();
                n++;
            end while (!gi && n < 10);
            chk("i_seq_grant", gi, 1);
            if (s > 0)
                chk("i_rate", cyc - prev, 2);
            prev = cyc;
            cycle();
            chk("i_seq_data", i_rdata, init_word(int'(seq[s])));
        end
        i_req = 1'b0;
        cycle();

        d_op(1'b0, 32'h00000404, 32'h0);
        chk("aerr_set", addr_err, 1);
        chk("aerr_data", d_rdata, init_word(4));
        repeat (3) cycle();
        chk("aerr_sticky", addr_err, 1);

        // reset lands inside the write's access cycle, before the falling edge
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
        cycle();
        #1 reset = 1'b1;
        #1;
        chk("mid_wen", mem_wen, 0);
        chk("mid_gnt", d_gnt, 0);
        apply_reset(2);
        cycle();
        d_op(1'b0, 32'h20, 32'h0);
        chk("mid_old", d_rdata, 32'h11111111);
        cycle();

        i_req = 1'b1; i_addr = 32'h30;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h31;
        ic = 1'b0; dc = 1'b0;
        run(1, 1);
        chk("tie_first_i", i_gnt, 1);
        run(14, 1);

        run(400, 0);
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (4) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-port 1024-word `Memory`. It shares the memory between an instruction-fetch port (I, read-only) and a data port (D, read/write). Each winning request becomes one registered single-cycle memory access, with round-robin fairness and a one-cycle registered response. It sits between the processor datapath and `Memory`. It guarantees `mem_ren`/`mem_wen` are never both high and flags out-of-range addresses.

## Interface
- `AW`, 32, address width (matches `Memory` addr)
- `DW`, 32, data width (matches `Memory` din/dout)
- `clock`  in  1  single clock, rising-edge logic
- `reset`  in  1  asynchronous, active-high reset
- `i_req`  in  1  instruction read request; held with `i_addr` until granted
- `i_addr`  in  AW  instruction word address
- `i_gnt`  out  1  I request accepted; high during the access cycle
- `i_valid`  out  1  `i_rdata` valid, one-cycle pulse
- `i_rdata`  out  DW  read data for I
- `d_req`  in  1  data request; held with `d_we`, `d_addr`, `d_wdata` until granted
- `d_we`  in  1  1 = write, 0 = read
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  write data
- `d_gnt`  out  1  D request accepted; high during the access cycle
- `d_valid`  out  1  D completion pulse; `d_rdata` meaningful for reads only
- `d_rdata`  out  DW  read data for D
- `mem_ren`  out  1  to `Memory` ren
- `mem_wen`  out  1  to `Memory` wen
- `mem_addr`  out  AW  to `Memory` addr
- `mem_din`  out  DW  to `Memory` din
- `mem_dout`  in  DW  from `Memory` dout (combinational read)
- `addr_err`  out  1  sticky: some granted address had bits [AW-1:10] nonzero

## Operation
- **FSM states:** IDLE and ACCESS.
- **IDLE:**
  - If any request is eligible, pick a winner.
  - Register the winner's op, addr and wdata.
  - Set the winner's gnt and go to ACCESS.
  - With no requests, stay in IDLE.
- **ACCESS:** one cycle.
  - Drive the memory from the registered transaction: `mem_ren = !we`, `mem_wen = we`.
  - `Memory` commits the write on the falling edge inside this cycle.
- **End of ACCESS (rising edge):**
  - For a read, capture `mem_dout` into the winner's rdata register.
  - Pulse the winner's valid, for both reads and writes.
  - If the other port is requesting, grant it immediately (ACCESS → ACCESS); otherwise return to IDLE.
- **Eligibility:** at the edge ending ACCESS, the port just served is not eligible. Its `req` is still the old request at that edge. So a port can be granted at most every 2nd cycle, while alternating I/D traffic keeps the memory busy every cycle.
- **Round robin:**
  - When both ports are eligible, grant the port not served last.
  - The last-served pointer resets to D, so I wins the first tie.
- **Requester rule:** a requester may change `req` and its payload at the edge that ends its gnt cycle.
- **I port:** always a read.
- **`addr_err`:** set at grant if the registered addr has bits [AW-1:10] nonzero. The access still proceeds (`Memory` wraps on addr[9:0]).
- **Idle memory drive:** outside ACCESS, `mem_ren = mem_wen = 0`, and `mem_addr` and `mem_din` are 0.

## Timing
- **Reset values:** state IDLE, all gnt/valid/ren/wen 0, rdata 0, `mem_addr`/`mem_din` 0, `addr_err` 0, pointer D.
- **Latency:** req sampled high at edge k → gnt and memory access in cycle k..k+1 → valid and rdata in cycle k+1..k+2. Read latency is 2 edges from the first sampling edge.
- **Throughput:** 1 access/cycle with alternating ports; 1 per 2 cycles for a single port.
- **Reset asserted mid-ACCESS:** outputs drop immediately and asynchronously to reset values. The pending write is suppressed because `mem_wen` is low before the falling edge, and no valid is issued.
- **Mutual exclusion:** gnt is one-hot or zero. `mem_ren & mem_wen` is never 1.

## Structure
- **Package `mem_arb_pkg`:**
  - state encoding (IDLE = 0, ACCESS = 1)
  - port ids (PORT_I = 0, PORT_D = 1)
  - `MEM_ADDR_BITS` = 10
- **Sub-module `mem_arb_rr`:** combinational 2-way round-robin pick. Inputs: eligible mask and last-served pointer. Output: one-hot grant.
- **Top level:** FSM, transaction register, response registers and the memory drive.

## Test plan
- **Reset values:** reset high for 2 cycles, then low with no requests → all outputs 0, memory idle indefinitely.
- **D write then read:** D write addr 0x10 data 0xCAFEF00D, then D read addr 0x10 → `d_valid` pulses twice; second `d_rdata` = 0xCAFEF00D; read `d_valid` exactly 2 edges after `d_req` first sampled.
- **Tie and alternation:** I and D both request from the same edge, held → first grant I (reset pointer), then D; strict alternation at 1 access/cycle; never two gnts in one cycle; ren & wen never both high.
- **Single-port rate:** I alone holding req continuously with addr 0x4, 0x8, 0xC updated after each gnt → grants every 2nd cycle, rdata matches preloaded memory words.
- **Address error:** D read addr 0x00000404 → `addr_err` sets and stays set; `d_rdata` = word at index 0x004.
- **Reset mid-write:** reset asserted during the ACCESS cycle of a D write to 0x20 (old value 0x11111111) → no valid pulse; a subsequent read of 0x20 returns 0x11111111.
